// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the ultrasonic scan scheduler: FSM states, distance width,
// and the echo-cycles to millimetre conversion (34 / 10000 at 50 MHz).
package ultrasonic_pkg;

    localparam int DIST_W = 16;
    localparam int MM_NUM = 34;
    localparam int MM_DEN = 10000;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_HOLDOFF   = 3'd4
    } scan_state_t;

    // 32-bit product, truncating divide, saturate to the 16-bit distance range.
    function automatic logic [DIST_W-1:0] cycles_to_mm(input logic [31:0] cycles);
        logic [31:0] prod;
        logic [31:0] quot;
        prod = cycles * 32'(MM_NUM);
        quot = prod / 32'(MM_DEN);
        return (quot > 32'h0000_FFFF) ? 16'hFFFF : quot[DIST_W-1:0];
    endfunction

endpackage

// File: rtl/ultrasonic_echo_timer.sv
// Echo front end for the selected sensor: 2-flop synchronizers on every echo pin, edge detect
// on the selected channel, echo-high cycle counter and the trig-fall based timeout timer.
module ultrasonic_echo_timer
    import ultrasonic_pkg::*;
#(
    parameter int N_SENS       = 3,
    parameter int ECHO_TIMEOUT = 550_000,
    parameter int SEL_W        = 2
) (
    input  logic              clk_50M,
    input  logic              reset,
    input  logic [N_SENS-1:0] echo_rx,
    input  logic [SEL_W-1:0]  sel,
    input  logic              clr,
    input  logic              wait_rise,
    input  logic              measure,
    output logic              echo_rise,
    output logic              echo_fall,
    output logic              echo_timeout,
    output logic [31:0]       echo_cycles
);

    logic [N_SENS-1:0] sync1;
    logic [N_SENS-1:0] sync2;
    logic              echo_now;
    logic              echo_prev;
    logic [31:0]       tmr;

    assign echo_now     = sync2[sel];
    assign echo_rise    = echo_now & ~echo_prev;
    assign echo_fall    = ~echo_now & echo_prev;
    assign echo_timeout = (wait_rise | measure) && (tmr == 32'(ECHO_TIMEOUT - 1));

    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            sync1       <= '0;
            sync2       <= '0;
            echo_prev   <= 1'b0;
            tmr         <= '0;
            echo_cycles <= '0;
        end else begin
            sync1     <= echo_rx;
            sync2     <= sync1;
            echo_prev <= echo_now;
            if (clr)
                tmr <= '0;
            else if (wait_rise | measure)
                tmr <= tmr + 32'd1;
            // The rise cycle itself counts as the first echo-high cycle.
            if (clr)
                echo_cycles <= '0;
            else if (wait_rise && echo_rise)
                echo_cycles <= 32'd1;
            else if (measure && echo_now)
                echo_cycles <= echo_cycles + 32'd1;
        end
    end

endmodule

// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin scheduler firing one ultrasonic sensor per slot and publishing distances in mm.
// Optional NEAREST_TRACK_EN adds a registered nearest-obstacle tracker (nearest_dist/nearest_chan).
module ultrasonic_scan_scheduler
    import ultrasonic_pkg::*;
#(
    parameter int N_SENS       = 3,
    parameter int TRIG_CYCLES  = 500,
    parameter int ECHO_TIMEOUT = 550_000,
    parameter int SLOT_CYCLES  = 600_000,
    parameter int OBST_MM      = 70,
    localparam int SEL_W       = (N_SENS > 1) ? $clog2(N_SENS) : 1
) (
    input  logic                     clk_50M,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [N_SENS-1:0]        chan_mask,
    input  logic [N_SENS-1:0]        echo_rx,
    output logic [N_SENS-1:0]        trig,
    output logic                     busy,
    output logic                     meas_valid,
    output logic [SEL_W-1:0]         meas_chan,
    output logic [DIST_W-1:0]        meas_dist,
    output logic                     meas_timeout,
    output logic [DIST_W*N_SENS-1:0] dist_flat,
`ifdef NEAREST_TRACK_EN
    output logic [N_SENS-1:0]        obstacle,
    output logic [DIST_W-1:0]        nearest_dist,
    output logic [SEL_W-1:0]         nearest_chan
`else
    output logic [N_SENS-1:0]        obstacle
`endif
);

    scan_state_t       state;
    scan_state_t       state_nxt;
    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  rr;
    logic [SEL_W-1:0]  sel_inc;
    logic [SEL_W-1:0]  pick_base;
    logic [SEL_W-1:0]  pick;
    logic [SEL_W-1:0]  cand;
    logic              found;
    logic [31:0]       slot_cnt;
    logic              go;
    logic              trig_done;
    logic              slot_done;
    logic              enter_trig;
    logic              got_echo;
    logic              publish;
    logic [DIST_W-1:0] new_dist;
    logic [DIST_W-1:0] dist_q [N_SENS];
    logic              echo_rise;
    logic              echo_fall;
    logic              echo_timeout;
    logic [31:0]       echo_cycles;

    assign go         = enable && (chan_mask != '0);
    assign trig_done  = (slot_cnt == 32'(TRIG_CYCLES - 1));
    assign slot_done  = (slot_cnt == 32'(SLOT_CYCLES - 1));
    assign enter_trig = (state == S_IDLE || state == S_HOLDOFF) && (state_nxt == S_TRIG);
    assign sel_inc    = (sel == SEL_W'(N_SENS - 1)) ? '0 : sel + 1'b1;
    // At holdoff end the pointer has not yet advanced, so search from sel+1 directly.
    assign pick_base  = (state == S_HOLDOFF) ? sel_inc : rr;
    assign got_echo   = (state == S_MEASURE) && echo_fall;
    assign publish    = ((state == S_WAIT_RISE) && echo_timeout) ||
                        ((state == S_MEASURE) && (echo_fall || echo_timeout));
    assign new_dist   = got_echo ? cycles_to_mm(echo_cycles) : '0;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = pick_base;
        for (int k = 0; k < N_SENS; k++) begin
            if (!found && chan_mask[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
            cand = (cand == SEL_W'(N_SENS - 1)) ? '0 : cand + 1'b1;
        end
    end

    ultrasonic_echo_timer #(
        .N_SENS      (N_SENS),
        .ECHO_TIMEOUT(ECHO_TIMEOUT),
        .SEL_W       (SEL_W)
    ) u_echo_timer (
        .clk_50M     (clk_50M),
        .reset       (reset),
        .echo_rx     (echo_rx),
        .sel         (sel),
        .clr         (state == S_TRIG),
        .wait_rise   (state == S_WAIT_RISE),
        .measure     (state == S_MEASURE),
        .echo_rise   (echo_rise),
        .echo_fall   (echo_fall),
        .echo_timeout(echo_timeout),
        .echo_cycles (echo_cycles)
    );

    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (go) state_nxt = S_TRIG;
            S_TRIG:      if (trig_done) state_nxt = S_WAIT_RISE;
            S_WAIT_RISE: if (echo_timeout) state_nxt = S_HOLDOFF;
                         else if (echo_rise) state_nxt = S_MEASURE;
            S_MEASURE:   if (echo_fall || echo_timeout) state_nxt = S_HOLDOFF;
            S_HOLDOFF:   if (slot_done) state_nxt = go ? S_TRIG : S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        trig = '0;
        busy = (state != S_IDLE);
        if (state == S_TRIG)
            trig[sel] = 1'b1;
    end

    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            sel          <= '0;
            rr           <= '0;
            slot_cnt     <= '0;
            meas_valid   <= 1'b0;
            meas_chan    <= '0;
            meas_dist    <= '0;
            meas_timeout <= 1'b0;
            for (int i = 0; i < N_SENS; i++)
                dist_q[i] <= '0;
        end else begin
            meas_valid <= publish;
            if (enter_trig || state_nxt == S_IDLE)
                slot_cnt <= '0;
            else
                slot_cnt <= slot_cnt + 32'd1;
            if (enter_trig)
                sel <= pick;
            if (state == S_HOLDOFF && slot_done)
                rr <= sel_inc;
            if (publish) begin
                meas_chan    <= sel;
                meas_dist    <= new_dist;
                meas_timeout <= ~got_echo;
                dist_q[sel]  <= new_dist;
            end
        end
    end

    always_comb begin
        dist_flat = '0;
        obstacle  = '0;
        for (int i = 0; i < N_SENS; i++) begin
            dist_flat[DIST_W*i +: DIST_W] = dist_q[i];
            obstacle[i] = (dist_q[i] != '0) && (dist_q[i] < DIST_W'(OBST_MM));
        end
    end

`ifdef NEAREST_TRACK_EN
    logic [DIST_W-1:0] best_dist;
    logic [SEL_W-1:0]  best_chan;

    // Strict less-than keeps the lowest index on ties; zero distances never qualify.
    always_comb begin
        best_dist = '0;
        best_chan = '0;
        for (int i = 0; i < N_SENS; i++) begin
            if (dist_q[i] != '0 && (best_dist == '0 || dist_q[i] < best_dist)) begin
                best_dist = dist_q[i];
                best_chan = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            nearest_dist <= '0;
            nearest_chan <= '0;
        end else begin
            nearest_dist <= best_dist;
            nearest_chan <= best_chan;
        end
    end
`endif

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// Directed bench for ultrasonic_scan_scheduler with shortened timing; a monitor pops expected
// trig order and measurement results from queues filled by the stimulus process.
module tb_ultrasonic_scan_scheduler;

    localparam int N        = 3;
    localparam int TRIG     = 10;
    localparam int ET       = 4000;
    localparam int SLOT     = 4500;
    localparam int OBST     = 8;
    localparam int ECHO_DLY = 50;
    localparam int W        = 20;

    logic          clk_50M   = 1'b0;
    logic          reset     = 1'b0;
    logic          enable    = 1'b0;
    logic [N-1:0]  chan_mask = '0;
    logic [N-1:0]  echo_rx   = '0;
    logic [N-1:0]  trig;
    logic          busy;
    logic          meas_valid;
    logic [1:0]    meas_chan;
    logic [15:0]   meas_dist;
    logic          meas_timeout;
    logic [16*N-1:0] dist_flat;
    logic [N-1:0]  obstacle;
`ifdef NEAREST_TRACK_EN
    logic [15:0]   nearest_dist;
    logic [1:0]    nearest_chan;
`endif

    ultrasonic_scan_scheduler #(
        .N_SENS      (N),
        .TRIG_CYCLES (TRIG),
        .ECHO_TIMEOUT(ET),
        .SLOT_CYCLES (SLOT),
        .OBST_MM     (OBST)
    ) dut (
        .clk_50M     (clk_50M),
        .reset       (reset),
        .enable      (enable),
        .chan_mask   (chan_mask),
        .echo_rx     (echo_rx),
        .trig        (trig),
        .busy        (busy),
        .meas_valid  (meas_valid),
        .meas_chan   (meas_chan),
        .meas_dist   (meas_dist),
        .meas_timeout(meas_timeout),
        .dist_flat   (dist_flat),
`ifdef NEAREST_TRACK_EN
        .obstacle    (obstacle),
        .nearest_dist(nearest_dist),
        .nearest_chan(nearest_chan)
`else
        .obstacle    (obstacle)
`endif
    );

    // clock / cycle counter
    always #10 clk_50M = ~clk_50M;
    int cyc = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [1:0]   trig_q[$];
    int popped        = 0;
    int rise_count    = 0;
    int last_rise     = -1;
    int last_rise_any = 0;
    int onehot_bad    = 0;
    int trig_fall_cyc [N];
    int echo_fall_cyc [N];
    int echo_len      [N];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_meas(input int ch, input int d, input bit to, input bit ob);
        exp_q.push_back({2'(ch), 16'(d), to, ob});
    endtask

    task automatic expect_trig(input int ch);
        trig_q.push_back(2'(ch));
    endtask

    task automatic wait_popped(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (popped < target && n < budget) begin
            @(negedge clk_50M);
            n++;
        end
        check(name, popped, target);
    endtask

    // sensor model: echo starts ECHO_DLY cycles after trig fall and stays high echo_len cycles
    initial begin : sensor
        int ch;
        forever begin
            wait (trig != '0);
            ch = trig[0] ? 0 : (trig[1] ? 1 : 2);
            wait (trig == '0);
            if (reset && echo_len[ch] != 0) begin
                repeat (ECHO_DLY) @(posedge clk_50M);
                #1 echo_rx[ch] = 1'b1;
                repeat (echo_len[ch]) @(posedge clk_50M);
                #1 echo_rx[ch] = 1'b0;
                echo_fall_cyc[ch] = cyc;
            end
        end
    end

    // monitor / scoreboard
    logic [N-1:0] prev_trig = '0;
    logic [W-1:0] ex;
    logic [1:0]   et;
    int           ch_m;
    initial begin : monitor
        forever begin
            @(negedge clk_50M);
            if (!reset) begin
                prev_trig = '0;
                last_rise = -1;
            end else begin
                if ($countones(trig) > 1) onehot_bad++;
                for (int i = 0; i < N; i++) begin
                    if (trig[i] && !prev_trig[i]) begin
                        rise_count++;
                        if (trig_q.size() == 0)
                            check("trig_unexpected", i, -1);
                        else begin
                            et = trig_q.pop_front();
                            check("trig_chan", i, int'(et));
                        end
                        if (last_rise >= 0) check("trig_period", cyc - last_rise, SLOT);
                        last_rise     = cyc;
                        last_rise_any = cyc;
                    end
                    if (!trig[i] && prev_trig[i]) trig_fall_cyc[i] = cyc;
                end
                prev_trig = trig;
                if (!busy) last_rise = -1;
                if (meas_valid) begin
                    if (exp_q.size() == 0)
                        check("meas_unexpected", int'(meas_chan), -1);
                    else begin
                        ex   = exp_q.pop_front();
                        ch_m = int'(ex[19:18]);
                        check("meas_chan", int'(meas_chan), ch_m);
                        check("meas_dist", int'(meas_dist), int'(ex[17:2]));
                        check("meas_timeout", int'(meas_timeout), int'(ex[1]));
                        check("obstacle", int'(obstacle[ch_m]), int'(ex[0]));
                        check("dist_flat", int'(dist_flat[16*ch_m +: 16]), int'(ex[17:2]));
                        if (ex[1])
                            check("timeout_latency", cyc - trig_fall_cyc[ch_m], ET);
                        else
                            check("echo_latency", cyc - echo_fall_cyc[ch_m], 3);
                        popped++;
                    end
                end
            end
        end
    end

    // stimulus
    int n;
    int rc;
    initial begin : stimulus
        echo_len = '{3000, 2000, 0};
        repeat (3) @(posedge clk_50M);
        #1;
        check("rst_trig", int'(trig), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_meas_valid", int'(meas_valid), 0);
        check("rst_dist_flat", int'(dist_flat != '0), 0);
        @(posedge clk_50M);
        #1 reset = 1'b1;

        // all channels: echo 3000 -> 10 mm, echo 2000 -> 6 mm (obstacle), no echo -> timeout
        expect_trig(0); expect_trig(1); expect_trig(2);
        expect_meas(0, 10, 1'b0, 1'b0);
        expect_meas(1, 6, 1'b0, 1'b1);
        expect_meas(2, 0, 1'b1, 1'b0);
        chan_mask = 3'b111;
        enable    = 1'b1;
        wait_popped(3, 3 * SLOT, "phase1_results");

        // mask 101: channel 1 skipped; channel 2 now returns 1000 cycles -> 3 mm
        chan_mask   = 3'b101;
        echo_len[2] = 1000;
        expect_trig(0); expect_trig(2); expect_trig(0); expect_trig(2);
        expect_meas(0, 10, 1'b0, 1'b0);
        expect_meas(2, 3, 1'b0, 1'b1);
        expect_meas(0, 10, 1'b0, 1'b0);
        expect_meas(2, 3, 1'b0, 1'b1);
        wait_popped(7, 4 * SLOT, "phase2_results");

        // single channel, obstacle boundary: 8 mm is not an obstacle, 7 mm is
        chan_mask   = 3'b010;
        echo_len[1] = 2353;
        expect_trig(1);
        expect_meas(1, 8, 1'b0, 1'b0);
        wait_popped(8, 2 * SLOT, "phase3_boundary8");
        echo_len[1] = 2352;
        expect_trig(1);
        expect_meas(1, 7, 1'b0, 1'b1);
        wait_popped(9, 2 * SLOT, "phase3_boundary7");

        // enable dropped during MEASURE: result still published, then idle
        expect_trig(1);
        expect_meas(1, 7, 1'b0, 1'b1);
        n = 0;
        while (!echo_rx[1] && n < 2 * SLOT) begin
            @(negedge clk_50M);
            n++;
        end
        check("echo1_seen", int'(echo_rx[1]), 1);
        repeat (100) @(posedge clk_50M);
        #1 enable = 1'b0;
        wait_popped(10, 2 * SLOT, "phase3_disable_result");
        n = 0;
        while (busy && n < 2 * SLOT) begin
            @(negedge clk_50M);
            n++;
        end
        check("busy_fall_at_slot_end", cyc - last_rise_any, SLOT);
        rc = rise_count;
        repeat (SLOT + SLOT / 2) @(negedge clk_50M);
        check("no_trig_after_disable", rise_count, rc);
        check("busy_idle", int'(busy), 0);

        // reset mid-TRIG: rr points at channel 2 after the channel 1 slot
        chan_mask = 3'b111;
        enable    = 1'b1;
        expect_trig(2);
        n = 0;
        while (!trig[2] && n < 100) begin
            @(negedge clk_50M);
            n++;
        end
        check("reset_slot_trig", int'(trig), 4);
        repeat (3) @(posedge clk_50M);
        #1 reset = 1'b0;
        #1;
        check("midreset_trig", int'(trig), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_dist_flat", int'(dist_flat != '0), 0);
        check("midreset_obstacle", int'(obstacle), 0);
        check("midreset_meas_dist", int'(meas_dist), 0);
        check("midreset_meas_chan", int'(meas_chan), 0);
        check("midreset_meas_timeout", int'(meas_timeout), 0);
        expect_trig(0);
        expect_meas(0, 10, 1'b0, 1'b0);
        repeat (2) @(posedge clk_50M);
        #1 reset = 1'b1;
        wait_popped(11, 2 * SLOT, "restart_chan0_result");

        check("exp_q_left", exp_q.size(), 0);
        check("trig_q_left", trig_q.size(), 0);
        check("trig_onehot", onehot_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
